// File: rtl/uart_fifo_pico.sv
// uart_fifo_pico: memory-mapped full-duplex UART for the picoRV32 native bus,
// with TX/RX FIFOs, sticky error flags and a maskable level interrupt.

module uart_fifo_pico_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A full FIFO still takes a push when the same cycle pops; an empty one
   // never pops the entry being pushed.
   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end
endmodule

module uart_fifo_pico #(
   parameter logic [31:0] ADDR        = 32'h0200_0000,
   parameter int          DATA_BITS   = 8,
   parameter int          FIFO_DEPTH  = 16,
   parameter int          STOP_BITS   = 1,
   parameter int          DEFAULT_CPB = 1667
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   input  logic        rx_uart,
   output logic        tx_uart,
   output logic        irq
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

   logic        ack_q;
   logic [11:0] cpb;
   logic [1:0]  parity;
   logic        rx_irq_en;
   logic        tx_irq_en;
   logic        rx_overrun;
   logic        parity_err;
   logic        frame_err;
   logic        tx_ovf;

   logic                 tx_push, tx_pop, tx_full, tx_empty;
   logic [DATA_BITS-1:0] tx_head;
   logic [CW-1:0]        tx_count;
   logic                 rx_push, rx_pop, rx_full, rx_empty;
   logic [DATA_BITS-1:0] rx_head;
   logic [CW-1:0]        rx_count;
   logic [DATA_BITS-1:0] rx_push_data;
   logic                 rx_push_perr;
   logic                 frame_err_set;

   logic        sel_data, sel_status, sel_ctrl, is_write, accept;
   logic        tx_ovf_set, rx_overrun_set;
   logic [3:0]  clr;
   logic [31:0] status_word, ctrl_word, read_word;
   logic        tx_busy;
   logic        unused_bits;

   assign unused_bits = ^{mem_wdata[31:16], mem_wstrb[3:2]};

   assign sel_data   = (mem_addr == ADDR);
   assign sel_status = (mem_addr == ADDR + 32'd4);
   assign sel_ctrl   = (mem_addr == ADDR + 32'd8);
   assign is_write   = |mem_wstrb;
   assign accept     = mem_valid && !ack_q && (sel_data || sel_status || sel_ctrl);

   assign tx_push        = accept && sel_data && is_write && mem_wstrb[0];
   assign rx_pop         = accept && sel_data && !is_write;
   assign tx_ovf_set     = tx_push && tx_full && !tx_pop;
   assign rx_overrun_set = rx_push && rx_full && !rx_pop;
   assign clr = (accept && sel_status && is_write && mem_wstrb[0]) ? mem_wdata[7:4] : 4'd0;

   assign status_word = {8'(tx_count), 8'(rx_count), 7'd0, tx_busy,
                         tx_ovf, frame_err, parity_err, rx_overrun,
                         rx_full, rx_empty, tx_empty, tx_full};
   assign ctrl_word   = {16'd0, tx_irq_en, rx_irq_en, parity, cpb};

   always_comb begin
      read_word = 32'd0;
      if (sel_data && !rx_empty) read_word = 32'(rx_head);
      else if (sel_status)       read_word = status_word;
      else if (sel_ctrl)         read_word = ctrl_word;
   end

   // ack_q stays set while the master holds mem_valid, so a held request
   // produces exactly one acknowledge and one side effect.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q     <= 1'b0;
         mem_ready <= 1'b0;
         mem_rdata <= 32'd0;
      end else begin
         mem_ready <= accept;
         mem_rdata <= (accept && !is_write) ? read_word : 32'd0;
         if (accept)          ack_q <= 1'b1;
         else if (!mem_valid) ack_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cpb       <= 12'(DEFAULT_CPB);
         parity    <= 2'b00;
         rx_irq_en <= 1'b0;
         tx_irq_en <= 1'b0;
      end else if (accept && sel_ctrl && is_write) begin
         if (mem_wstrb[0]) cpb[7:0] <= mem_wdata[7:0];
         if (mem_wstrb[1]) begin
            cpb[11:8] <= mem_wdata[11:8];
            parity    <= mem_wdata[13:12];
            rx_irq_en <= mem_wdata[14];
            tx_irq_en <= mem_wdata[15];
         end
      end
   end

   // A set in the same cycle as a W1C clear wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_overrun <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         tx_ovf     <= 1'b0;
         irq        <= 1'b0;
      end else begin
         rx_overrun <= (rx_overrun & ~clr[0]) | rx_overrun_set;
         parity_err <= (parity_err & ~clr[1]) | (rx_push & rx_push_perr);
         frame_err  <= (frame_err  & ~clr[2]) | frame_err_set;
         tx_ovf     <= (tx_ovf     & ~clr[3]) | tx_ovf_set;
         irq        <= (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty);
      end
   end

   uart_fifo_pico_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(tx_push), .push_data(mem_wdata[DATA_BITS-1:0]),
      .pop(tx_pop), .head(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty)
   );

   uart_fifo_pico_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(rx_push), .push_data(rx_push_data),
      .pop(rx_pop), .head(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
   );

   state_t               tx_state;
   logic [11:0]          tx_cpb, tx_cnt;
   logic                 tx_par_en, tx_par_val;
   logic [DATA_BITS-1:0] tx_shift;
   logic [2:0]           tx_bit;
   logic                 tx_stop;
   logic                 tx_start;

   // A new frame starts from IDLE or directly at the end of the last stop
   // period, so queued bytes go out with no idle gap.
   assign tx_start = !tx_empty && ((tx_state == S_IDLE) ||
                     (tx_state == S_STOP && tx_cnt == 12'd0 && tx_stop == 1'(STOP_BITS-1)));
   assign tx_pop   = tx_start;
   assign tx_busy  = (tx_state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= S_IDLE;
         tx_uart  <= 1'b1;
      end else begin
         case (tx_state)
            S_START: begin
               if (tx_cnt == 12'd0) begin
                  tx_state <= S_DATA;
                  tx_uart  <= tx_shift[0];
                  tx_bit   <= 3'd0;
                  tx_cnt   <= tx_cpb - 12'd1;
               end else tx_cnt <= tx_cnt - 12'd1;
            end
            S_DATA: begin
               if (tx_cnt == 12'd0) begin
                  tx_cnt <= tx_cpb - 12'd1;
                  if (tx_bit == 3'(DATA_BITS-1)) begin
                     tx_stop <= 1'b0;
                     if (tx_par_en) begin
                        tx_state <= S_PARITY;
                        tx_uart  <= tx_par_val;
                     end else begin
                        tx_state <= S_STOP;
                        tx_uart  <= 1'b1;
                     end
                  end else begin
                     tx_bit   <= tx_bit + 3'd1;
                     tx_shift <= tx_shift >> 1;
                     tx_uart  <= tx_shift[1];
                  end
               end else tx_cnt <= tx_cnt - 12'd1;
            end
            S_PARITY: begin
               if (tx_cnt == 12'd0) begin
                  tx_state <= S_STOP;
                  tx_uart  <= 1'b1;
                  tx_cnt   <= tx_cpb - 12'd1;
               end else tx_cnt <= tx_cnt - 12'd1;
            end
            S_STOP: begin
               if (tx_cnt == 12'd0) begin
                  if (tx_stop == 1'(STOP_BITS-1)) tx_state <= S_IDLE;
                  else begin
                     tx_stop <= 1'b1;
                     tx_cnt  <= tx_cpb - 12'd1;
                  end
               end else tx_cnt <= tx_cnt - 12'd1;
            end
            default: tx_state <= S_IDLE;
         endcase
         if (tx_start) begin
            tx_state   <= S_START;
            tx_uart    <= 1'b0;
            tx_shift   <= tx_head;
            tx_cpb     <= cpb;
            tx_cnt     <= cpb - 12'd1;
            tx_par_en  <= parity[0] ^ parity[1];
            tx_par_val <= parity_bit(tx_head, parity[1]);
         end
      end
   end

   state_t               rx_state;
   logic                 rx_s1, rx_s2, rx_prev;
   logic [11:0]          rx_cpb, rx_cnt;
   logic                 rx_par_en, rx_par_odd;
   logic [DATA_BITS-1:0] rx_shift;
   logic [2:0]           rx_bit;
   logic                 rx_stop, rx_perr, rx_ferr;

   // Only a high-to-low transition arms the receiver, so after a framing
   // error the line must return high before the next start is recognised.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1         <= 1'b1;
         rx_s2         <= 1'b1;
         rx_prev       <= 1'b1;
         rx_state      <= S_IDLE;
         rx_push       <= 1'b0;
         frame_err_set <= 1'b0;
      end else begin
         rx_s1         <= rx_uart;
         rx_s2         <= rx_s1;
         rx_prev       <= rx_s2;
         rx_push       <= 1'b0;
         frame_err_set <= 1'b0;
         case (rx_state)
            S_IDLE: begin
               if (rx_prev && !rx_s2) begin
                  rx_state   <= S_START;
                  rx_cpb     <= cpb;
                  rx_cnt     <= cpb >> 1;
                  rx_par_en  <= parity[0] ^ parity[1];
                  rx_par_odd <= parity[1];
                  rx_perr    <= 1'b0;
                  rx_ferr    <= 1'b0;
               end
            end
            S_START: begin
               if (rx_cnt == 12'd0) begin
                  if (rx_s2) rx_state <= S_IDLE;
                  else begin
                     rx_state <= S_DATA;
                     rx_bit   <= 3'd0;
                     rx_cnt   <= rx_cpb - 12'd1;
                  end
               end else rx_cnt <= rx_cnt - 12'd1;
            end
            S_DATA: begin
               if (rx_cnt == 12'd0) begin
                  rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                  rx_cnt   <= rx_cpb - 12'd1;
                  if (rx_bit == 3'(DATA_BITS-1)) begin
                     rx_state <= rx_par_en ? S_PARITY : S_STOP;
                     rx_stop  <= 1'b0;
                  end else rx_bit <= rx_bit + 3'd1;
               end else rx_cnt <= rx_cnt - 12'd1;
            end
            S_PARITY: begin
               if (rx_cnt == 12'd0) begin
                  rx_perr  <= (rx_s2 != parity_bit(rx_shift, rx_par_odd));
                  rx_state <= S_STOP;
                  rx_stop  <= 1'b0;
                  rx_cnt   <= rx_cpb - 12'd1;
               end else rx_cnt <= rx_cnt - 12'd1;
            end
            S_STOP: begin
               if (rx_cnt == 12'd0) begin
                  if (rx_stop == 1'(STOP_BITS-1)) begin
                     rx_state <= S_IDLE;
                     if (rx_ferr || !rx_s2) frame_err_set <= 1'b1;
                     else begin
                        rx_push      <= 1'b1;
                        rx_push_data <= rx_shift;
                        rx_push_perr <= rx_perr;
                     end
                  end else begin
                     rx_ferr <= rx_ferr | !rx_s2;
                     rx_stop <= 1'b1;
                     rx_cnt  <= rx_cpb - 12'd1;
                  end
               end else rx_cnt <= rx_cnt - 12'd1;
            end
            default: rx_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_fifo_pico.sv
// Self-checking bench for uart_fifo_pico: bus access, loopback framing, parity,
// FIFO overflow/overrun, framing errors, glitch rejection, irq and reset.
module tb_uart_fifo_pico;
   localparam logic [31:0] BASE   = 32'h0200_0000;
   localparam logic [31:0] A_DATA = BASE;
   localparam logic [31:0] A_STAT = BASE + 32'd4;
   localparam logic [31:0] A_CTRL = BASE + 32'd8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_addr = 32'd0;
   logic [31:0] mem_wdata = 32'd0;
   logic [3:0]  mem_wstrb = 4'd0;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        rx_uart;
   logic        tx_uart;
   logic        irq;
   logic        loop_en = 1'b0;
   logic        rx_drv = 1'b1;

   int          tests = 0;
   int          fails = 0;
   logic [7:0]  exp_q[$];
   logic [19:0] line;
   logic        seen;
   logic [31:0] r;
   int          lat;
   logic [7:0]  b;

   assign rx_uart = loop_en ? tx_uart : rx_drv;

   always #5 clk = ~clk;

   uart_fifo_pico #(.ADDR(BASE), .DATA_BITS(8), .FIFO_DEPTH(16), .STOP_BITS(1), .DEFAULT_CPB(1667)) dut (
      .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .rx_uart(rx_uart), .tx_uart(tx_uart), .irq(irq)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd_val, output int cycles);
      int n = 0;
      @(negedge clk);
      mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
      do begin
         @(negedge clk);
         n++;
      end while (mem_ready !== 1'b1 && n < 20);
      if (mem_ready !== 1'b1) check_val("bus_ack", 32'(mem_ready), 32'd1);
      rd_val = mem_rdata;
      cycles = n;
      mem_valid = 1'b0; mem_wstrb = 4'd0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] dummy;
      int c;
      bus(a, d, 4'hF, dummy, c);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      int c;
      bus(a, 32'd0, 4'h0, v, c);
   endtask

   task automatic send_byte(input logic [7:0] v, input bit expect_rx);
      wr(A_DATA, 32'(v));
      if (expect_rx) exp_q.push_back(v);
   endtask

   task automatic rd_expect(input string tag);
      logic [31:0] v;
      logic [31:0] e;
      rd(A_DATA, v);
      e = 32'd0;
      if (exp_q.size() > 0) e = 32'(exp_q.pop_front());
      check_val(tag, v, e);
   endtask

   // Sample tx_uart mid-bit for nbits bit periods after the first start edge.
   task automatic capture(input int nbits, input int cpb, output logic [19:0] bits, output logic found);
      int n = 0;
      bits = '0;
      while (tx_uart !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      found = (tx_uart === 1'b0);
      repeat (cpb / 2) @(negedge clk);
      bits[0] = tx_uart;
      for (int i = 1; i < nbits; i++) begin
         repeat (cpb) @(negedge clk);
         bits[i] = tx_uart;
      end
   endtask

   task automatic inject(input logic [10:0] bits, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         rx_drv = bits[i];
         repeat (16) @(negedge clk);
      end
      rx_drv = 1'b1;
      repeat (16) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check_val("rst_tx_uart", 32'(tx_uart), 32'd1);
      check_val("rst_irq", 32'(irq), 32'd0);
      check_val("rst_ready", 32'(mem_ready), 32'd0);
      check_val("rst_rdata", mem_rdata, 32'd0);
      rst = 1'b0;

      // held request: one ack only
      @(negedge clk);
      mem_valid = 1'b1; mem_addr = A_STAT; mem_wstrb = 4'd0;
      @(negedge clk);
      check_val("stat_ready", 32'(mem_ready), 32'd1);
      check_val("stat_reset", mem_rdata, 32'h0000_0006);
      @(negedge clk);
      check_val("ready_one_cycle", 32'(mem_ready), 32'd0);
      check_val("rdata_idle_zero", mem_rdata, 32'd0);
      mem_valid = 1'b0;
      bus(A_CTRL, 32'd0, 4'h0, r, lat);
      check_val("ctrl_reset", r, 32'h0000_0683);
      check_val("read_latency", 32'(lat), 32'd1);

      // loopback, two back-to-back 8N1 frames at 16 clocks per bit
      wr(A_CTRL, 32'h0000_0010);
      loop_en = 1'b1;
      fork
         capture(20, 16, line, seen);
         begin
            send_byte(8'hAF, 1'b1);
            send_byte(8'hEE, 1'b1);
         end
      join
      check_val("tx_start_seen", 32'(seen), 32'd1);
      check_val("tx_two_frames", 32'(line), 32'({1'b1, 8'hEE, 1'b0, 1'b1, 8'hAF, 1'b0}));
      repeat (60) @(negedge clk);
      rd_expect("rx_byte0");
      rd_expect("rx_byte1");
      rd_expect("rx_empty_read");
      rd(A_STAT, r);
      check_val("rx_empty_flag", 32'(r[2]), 32'd1);

      // odd parity loopback
      wr(A_CTRL, 32'h0000_2010);
      b = 8'h55;
      fork
         capture(11, 16, line, seen);
         send_byte(b, 1'b1);
      join
      check_val("tx_odd_frame", 32'(line), 32'({1'b1, ~(^b), b, 1'b0}));
      repeat (40) @(negedge clk);
      rd_expect("rx_odd_byte");
      rd(A_STAT, r);
      check_val("no_parity_err", 32'(r[5]), 32'd0);

      // even-parity frame into an odd-parity receiver
      loop_en = 1'b0;
      inject({1'b1, ^b, b, 1'b0}, 11);
      exp_q.push_back(b);
      rd(A_STAT, r);
      check_val("parity_err_set", 32'(r[5]), 32'd1);
      rd_expect("rx_bad_parity_byte");
      wr(A_STAT, 32'h0000_0020);
      rd(A_STAT, r);
      check_val("parity_err_clr", 32'(r[5]), 32'd0);

      // TX overflow: first byte occupies the shifter for a very long frame
      wr(A_CTRL, 32'h0000_0FFF);
      for (int i = 0; i < 18; i++) send_byte(8'(i), 1'b0);
      rd(A_STAT, r);
      check_val("tx_overflow_status", r, 32'h1000_0185);
      check_val("tx_in_start_bit", 32'(tx_uart), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_val("mid_frame_rst_tx", 32'(tx_uart), 32'd1);
      rst = 1'b0;
      rd(A_STAT, r);
      check_val("post_rst_status", r, 32'h0000_0006);
      rd(A_CTRL, r);
      check_val("post_rst_ctrl", r, 32'h0000_0683);

      // RX overrun: 17 frames looped back, nothing read
      wr(A_CTRL, 32'h0000_0010);
      loop_en = 1'b1;
      for (int i = 0; i < 17; i++) send_byte(8'(i * 13 + 5), i < 16);
      repeat (17 * 160 + 100) @(negedge clk);
      rd(A_STAT, r);
      check_val("rx_overrun_status", r, 32'h0010_001A);
      for (int i = 0; i < 16; i++) rd_expect("rx_drain");
      wr(A_STAT, 32'h0000_00F0);

      // framing error, recovery, and glitch rejection
      loop_en = 1'b0;
      inject({1'b0, 8'h81, 1'b0}, 10);
      rd(A_STAT, r);
      check_val("frame_err_status", r, 32'h0000_0046);
      wr(A_STAT, 32'h0000_0040);
      b = 8'h3C;
      inject({1'b1, b, 1'b0}, 10);
      exp_q.push_back(b);
      rd_expect("rx_after_ferr");
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (3) @(negedge clk);
      rx_drv = 1'b1;
      repeat (200) @(negedge clk);
      rd(A_STAT, r);
      check_val("glitch_rejected", r, 32'h0000_0006);

      // receive interrupt
      wr(A_CTRL, 32'h0000_4010);
      repeat (2) @(negedge clk);
      check_val("irq_idle", 32'(irq), 32'd0);
      b = 8'hA5;
      inject({1'b1, b, 1'b0}, 10);
      exp_q.push_back(b);
      check_val("irq_rise", 32'(irq), 32'd1);
      rd_expect("irq_byte");
      check_val("irq_hold", 32'(irq), 32'd1);
      @(negedge clk);
      check_val("irq_fall", 32'(irq), 32'd0);

      // transmit-empty interrupt
      wr(A_CTRL, 32'h0000_8010);
      @(negedge clk);
      check_val("irq_tx_empty", 32'(irq), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
